fifo_wr_arbiter: RTL and testbench

//  Round-robin, burst-aware arbiter that shares the single write port of the async FIFO among N_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned DW_DEF        = 23;
  localparam int unsigned MAX_BURST_DEF = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = clog2(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  int unsigned j;

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      j = (32'(rr_ptr) + k - 1) % N_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter sharing the async FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned ID_W      = clog2(N_REQ_DEF),
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy,
  output logic                burst_trunc
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;

  arb_state_e       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             hold_valid;
  logic [DW-1:0]    hold_data;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             own_ready;
  logic             accept;
  logic             own_last;
  logic             at_limit;
  logic [DW-1:0]    own_data;
  logic [ID_W-1:0]  rr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign fifo_wr   = hold_valid & ~fifo_full;
  assign fifo_din  = hold_data;
  assign busy      = (state == BURST);
  // The hold register may refill in the same cycle it drains.
  assign own_ready = busy & (~hold_valid | fifo_wr);
  assign accept    = own_ready & req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign own_data  = req_data[32'(grant_id)*DW +: DW];
  assign at_limit  = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign rr_next   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = own_ready;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      burst_trunc <= 1'b0;
    end else begin
      burst_trunc <= 1'b0;

      if (accept) begin
        hold_data  <= own_data;
        hold_valid <= 1'b1;
      end else if (fifo_wr) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (own_last || at_limit) begin
              state       <= IDLE;
              rr_ptr      <= rr_next;
              burst_trunc <= ~own_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: fairness, bursts, full stall, truncation, wrap, reset.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 23;

  logic            wr_clk;
  logic            wr_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;
  logic            burst_trunc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DW        (DW),
    .ID_W      (2),
    .MAX_BURST (16)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_din    (fifo_din),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_trunc (burst_trunc)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // A write strobe seen at mid-cycle commits at the following rising edge.
  always @(negedge wr_clk)
    if (!wr_rst && fifo_wr) wr_q.push_back(fifo_din);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) @(posedge wr_clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic l, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_data%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_rst    = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    #1;
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_trunc", burst_trunc, 0);
    check("rst_din", fifo_din, 0);
    check("rst_gid", grant_id, 0);
    tick(2);
    wr_rst = 1'b0;
    tick();

    // Fairness: four one-beat bursts then wrap back to 0
    for (int unsigned i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, DW'(32'h10 + i));
    #1;
    for (int unsigned g = 0; g < 5; g++) begin
      check("fair_idle_busy", busy, 0);
      check("fair_idle_ready", req_ready, 0);
      check("fair_idle_wr", fifo_wr, (g > 0) ? 1 : 0);
      tick();
      check("fair_busy", busy, 1);
      check("fair_gid", grant_id, g % 4);
      check("fair_ready", req_ready, 4'd1 << (g % 4));
      check("fair_burst_wr", fifo_wr, 0);
      exp_q.push_back(DW'(32'h10 + (g % 4)));
      tick();
      if (g == 4) begin
        req_valid = '0;
        req_last  = '0;
        #1;
      end
    end
    tick(3);
    check_writes("fair_wr");

    // Five-beat burst from req 2 while req 3 waits
    set_req(2, 1'b1, 1'b0, DW'(1));
    set_req(3, 1'b1, 1'b1, DW'(32'h33));
    #1;
    check("burst_idle", busy, 0);
    tick();
    for (int unsigned b = 1; b <= 5; b++) begin
      check("burst_gid", grant_id, 2);
      check("burst_ready", req_ready, 4'b0100);
      check("burst_wr", fifo_wr, (b > 1) ? 1 : 0);
      exp_q.push_back(DW'(b));
      tick();
      if (b < 5) set_req(2, 1'b1, (b + 1 == 5), DW'(b + 1));
      else       set_req(2, 1'b0, 1'b0, '0);
      #1;
    end
    check("burst_tail_wr", fifo_wr, 1);
    check("burst_tail_din", fifo_din, 5);
    tick();
    check("burst_next_gid", grant_id, 3);
    check("burst_next_ready", req_ready, 4'b1000);
    exp_q.push_back(DW'(32'h33));
    tick();
    set_req(3, 1'b0, 1'b0, '0);
    tick(3);
    check_writes("burst_wr_seq");

    // Full stall mid-burst on req 0
    set_req(0, 1'b1, 1'b0, DW'(32'hA1));
    #1;
    tick();
    check("full_ready0", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b1, 1'b0, DW'(32'hA2));
    #1;
    check("full_wr_a1", fifo_wr, 1);
    check("full_ready1", req_ready, 4'b0001);
    tick();
    fifo_full = 1'b1;
    set_req(0, 1'b1, 1'b0, DW'(32'hA3));
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      check("full_stall_wr", fifo_wr, 0);
      check("full_stall_ready", req_ready, 0);
      check("full_stall_din", fifo_din, 32'hA2);
      check("full_stall_busy", busy, 1);
      tick();
      if (k == 2) begin
        fifo_full = 1'b0;
        #1;
      end
    end
    check("full_resume_wr", fifo_wr, 1);
    check("full_resume_ready", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b1, 1'b1, DW'(32'hA4));
    #1;
    check("full_a3_din", fifo_din, 32'hA3);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    #1;
    check("full_end_busy", busy, 0);
    check("full_end_din", fifo_din, 32'hA4);
    exp_q.push_back(DW'(32'hA1));
    exp_q.push_back(DW'(32'hA2));
    exp_q.push_back(DW'(32'hA3));
    exp_q.push_back(DW'(32'hA4));
    tick(3);
    check_writes("full_wr_seq");

    // Truncation: req 1 streams without last, req 2 is waiting
    set_req(1, 1'b1, 1'b0, DW'(32'h101));
    set_req(2, 1'b1, 1'b1, DW'(32'h77));
    #1;
    tick();
    for (int unsigned b = 1; b <= 16; b++) begin
      check("trunc_gid", grant_id, 1);
      check("trunc_ready", req_ready, 4'b0010);
      check("trunc_pulse_low", burst_trunc, 0);
      exp_q.push_back(DW'(32'h100 + b));
      tick();
      set_req(1, 1'b1, 1'b0, DW'(32'h100 + b + 1));
      #1;
    end
    check("trunc_pulse", burst_trunc, 1);
    check("trunc_idle", busy, 0);
    check("trunc_last_din", fifo_din, 32'h110);
    tick();
    check("trunc_next_gid", grant_id, 2);
    check("trunc_next_ready", req_ready, 4'b0100);
    check("trunc_pulse_once", burst_trunc, 0);
    exp_q.push_back(DW'(32'h77));
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    set_req(2, 1'b0, 1'b0, '0);
    #1;
    check("trunc_after", burst_trunc, 0);
    tick(3);
    check_writes("trunc_wr_seq");

    // Wrap: rr_ptr=3, only req 3 and req 0 valid; req 0 pauses mid-burst
    set_req(3, 1'b1, 1'b0, DW'(32'h31));
    set_req(0, 1'b1, 1'b0, DW'(32'h01));
    #1;
    tick();
    check("wrap_gid3", grant_id, 3);
    check("wrap_ready3", req_ready, 4'b1000);
    tick();
    set_req(3, 1'b1, 1'b1, DW'(32'h32));
    #1;
    tick();
    set_req(3, 1'b0, 1'b0, '0);
    #1;
    check("wrap_idle", busy, 0);
    tick();
    check("wrap_gid0", grant_id, 0);
    check("wrap_ready0", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b0, 1'b1, DW'(32'h02));
    #1;
    check("wrap_pause_busy", busy, 1);
    check("wrap_pause_gid", grant_id, 0);
    tick();
    set_req(0, 1'b1, 1'b1, DW'(32'h02));
    #1;
    check("wrap_hold_busy", busy, 1);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    #1;
    check("wrap_end", busy, 0);
    exp_q.push_back(DW'(32'h31));
    exp_q.push_back(DW'(32'h32));
    exp_q.push_back(DW'(32'h01));
    exp_q.push_back(DW'(32'h02));
    tick(3);
    check_writes("wrap_wr_seq");

    // Reset mid-burst with a beat stuck in the hold register
    fifo_full = 1'b1;
    set_req(1, 1'b1, 1'b0, DW'(32'hEE));
    #1;
    tick();
    check("mrst_ready", req_ready, 4'b0010);
    tick();
    check("mrst_held_wr", fifo_wr, 0);
    check("mrst_held_din", fifo_din, 32'hEE);
    wr_rst = 1'b1;
    #1;
    check("mrst_fifo_wr", fifo_wr, 0);
    check("mrst_ready0", req_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_trunc", burst_trunc, 0);
    check("mrst_din", fifo_din, 0);
    fifo_full = 1'b0;
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    wr_rst = 1'b0;
    tick(3);
    check_writes("mrst_no_write");
    set_req(0, 1'b1, 1'b1, DW'(5));
    set_req(2, 1'b1, 1'b1, DW'(6));
    #1;
    tick();
    check("mrst_ptr_gid", grant_id, 0);
    exp_q.push_back(DW'(5));
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    set_req(2, 1'b0, 1'b0, '0);
    tick(3);
    check_writes("mrst_after_wr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
